// File: rtl/uart_time_loader_if.sv
// Inbound serial line and stopwatch control strobes of the UART time loader.
interface uart_time_loader_if;
  logic        usb_rx;
  logic        start_pulse;
  logic        stop_pulse;
  logic        clear_pulse;
  logic        load_pulse;
  logic [15:0] load_digits;
  logic        frame_err;
  logic        cmd_err;

  // Host / line side: drives the serial line, observes the decoded commands.
  modport master (
    output usb_rx,
    input  start_pulse,
    input  stop_pulse,
    input  clear_pulse,
    input  load_pulse,
    input  load_digits,
    input  frame_err,
    input  cmd_err
  );

  // Loader side: receives the serial line, produces the decoded commands.
  modport slave (
    input  usb_rx,
    output start_pulse,
    output stop_pulse,
    output clear_pulse,
    output load_pulse,
    output load_digits,
    output frame_err,
    output cmd_err
  );
endinterface

// File: rtl/uart_time_loader.sv
// UART 8N1 receiver plus ASCII command decoder for the stopwatch:
// 'G' start, 'P' stop, 'R' clear, "Tmmss\r" load of a BCD time.
module uart_time_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input logic               clk,
  input logic               rst_n,
  uart_time_loader_if.slave bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    StWaitIdle, StIdle, StStart, StData, StStop, StRecover
  } rx_state_e;

  typedef enum logic [2:0] {
    PIdle, PM10, PM1, PS10, PS1, PCr
  } p_state_e;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic            rx_meta_q, rx_sync_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            stop_done_q, stop_done_d;
  logic            stop_bit_q, stop_bit_d;
  logic            byte_valid_q, frame_fault_q;

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.usb_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q    <= StWaitIdle;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      stop_done_q   <= 1'b0;
      stop_bit_q    <= 1'b1;
      byte_valid_q  <= 1'b0;
      frame_fault_q <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      stop_done_q   <= stop_done_d;
      stop_bit_q    <= stop_bit_d;
      // Byte/frame strobes land one cycle after the stop-bit sample.
      byte_valid_q  <= stop_done_q & stop_bit_q;
      frame_fault_q <= stop_done_q & ~stop_bit_q;
    end
  end

  // Receiver next-state: mid-bit sampling driven by a single bit-time counter.
  always_comb begin
    rx_state_d  = rx_state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    stop_done_d = 1'b0;
    stop_bit_d  = stop_bit_q;
    unique case (rx_state_q)
      StWaitIdle: begin
        // The synchronizer resets to 1, so a single high sample proves nothing;
        // demand a full bit time of idle before trusting a falling edge.
        if (!rx_sync_q) begin
          cnt_d = '0;
        end else if (cnt_q == FullCnt) begin
          cnt_d      = '0;
          rx_state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_sync_q) rx_state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d      = '0;
          rx_state_d = rx_sync_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == FullCnt) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) rx_state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == FullCnt) begin
          cnt_d       = '0;
          stop_done_d = 1'b1;
          stop_bit_d  = rx_sync_q;
          rx_state_d  = rx_sync_q ? StIdle : StRecover;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRecover: begin
        cnt_d = '0;
        if (rx_sync_q) rx_state_d = StIdle;
      end
      default: rx_state_d = StWaitIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command parser
  // ---------------------------------------------------------------------------
  p_state_e    p_state_q, p_state_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] digits_q, digits_d;
  logic        start_q, start_d, stop_q, stop_d, clear_q, clear_d;
  logic        load_q, load_d, frame_err_q, frame_err_d, cmd_err_q, cmd_err_d;
  logic [7:0]  rx_byte;

  // The shift register is idle from the stop sample until the next frame's
  // first data sample, so it is safe to decode directly.
  assign rx_byte = shift_q;

  function automatic logic digit_ok(input logic [7:0] b, input logic [7:0] hi);
    return (b >= 8'h30) && (b <= hi);
  endfunction

  // Parser state and registered command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state_q   <= PIdle;
      shadow_q    <= '0;
      digits_q    <= '0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      clear_q     <= 1'b0;
      load_q      <= 1'b0;
      frame_err_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      p_state_q   <= p_state_d;
      shadow_q    <= shadow_d;
      digits_q    <= digits_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      clear_q     <= clear_d;
      load_q      <= load_d;
      frame_err_q <= frame_err_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Parser next-state: single-byte commands from idle, digit sequence after 'T'.
  always_comb begin
    p_state_d   = p_state_q;
    shadow_d    = shadow_q;
    digits_d    = digits_q;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    clear_d     = 1'b0;
    load_d      = 1'b0;
    frame_err_d = frame_fault_q;
    cmd_err_d   = 1'b0;
    if (frame_fault_q) begin
      // A corrupted byte aborts any command in progress.
      cmd_err_d = (p_state_q != PIdle);
      p_state_d = PIdle;
    end else if (byte_valid_q) begin
      unique case (p_state_q)
        PIdle: begin
          case (rx_byte)
            8'h47:   start_d   = 1'b1;
            8'h50:   stop_d    = 1'b1;
            8'h52:   clear_d   = 1'b1;
            8'h54:   p_state_d = PM10;
            default: ;
          endcase
        end
        PM10: begin
          if (digit_ok(rx_byte, 8'h35)) begin
            shadow_d[15:12] = rx_byte[3:0];
            p_state_d       = PM1;
          end else begin
            cmd_err_d = 1'b1;
            p_state_d = PIdle;
          end
        end
        PM1: begin
          if (digit_ok(rx_byte, 8'h39)) begin
            shadow_d[11:8] = rx_byte[3:0];
            p_state_d      = PS10;
          end else begin
            cmd_err_d = 1'b1;
            p_state_d = PIdle;
          end
        end
        PS10: begin
          if (digit_ok(rx_byte, 8'h35)) begin
            shadow_d[7:4] = rx_byte[3:0];
            p_state_d     = PS1;
          end else begin
            cmd_err_d = 1'b1;
            p_state_d = PIdle;
          end
        end
        PS1: begin
          if (digit_ok(rx_byte, 8'h39)) begin
            shadow_d[3:0] = rx_byte[3:0];
            p_state_d     = PCr;
          end else begin
            cmd_err_d = 1'b1;
            p_state_d = PIdle;
          end
        end
        PCr: begin
          if (rx_byte == 8'h0D) begin
            digits_d = shadow_q;
            load_d   = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
          p_state_d = PIdle;
        end
        default: p_state_d = PIdle;
      endcase
    end
  end

  assign bus.start_pulse = start_q;
  assign bus.stop_pulse  = stop_q;
  assign bus.clear_pulse = clear_q;
  assign bus.load_pulse  = load_q;
  assign bus.load_digits = digits_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_uart_time_loader.sv
// Directed bench for uart_time_loader: table of serial frames with the pulse
// expected at a fixed cycle after each frame, plus glitch and reset sequences.
module tb_uart_time_loader;

  localparam int unsigned Cpb  = 16;
  localparam int unsigned Half = Cpb / 2;
  // Cycles from the drive cycle of the start bit to the visible output pulse:
  // 1 to the first sampling edge, 2 synchronizer, HALF_BIT + 9 bit times to
  // the stop sample, 2 more to the registered pulse.
  localparam int unsigned Lat  = 1 + 2 + Half + 9 * Cpb + 2;

  // Pulse vector bit order: {start, stop, clear, load, frame_err, cmd_err}
  localparam logic [5:0] ExNone  = 6'b000000;
  localparam logic [5:0] ExStart = 6'b100000;
  localparam logic [5:0] ExStop  = 6'b010000;
  localparam logic [5:0] ExClear = 6'b001000;
  localparam logic [5:0] ExLoad  = 6'b000100;
  localparam logic [5:0] ExFrCmd = 6'b000011;
  localparam logic [5:0] ExCmd   = 6'b000001;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int          idle_bits;
    logic [5:0]  exp;
    logic [15:0] dig;
  } vec_t;

  typedef struct {
    int unsigned cyc;
    logic [5:0]  exp;
    logic [15:0] dig;
    int          idx;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int          n_checks;
  int          n_fail;
  int          pulse_cnt;
  logic [5:0]  obs;
  vec_t        tbl[$];
  exp_t        exp_q[$];

  uart_time_loader_if bus ();

  uart_time_loader #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle: an expected slot must match exactly; anywhere else no pulse.
  always @(negedge clk) begin
    obs = {bus.start_pulse, bus.stop_pulse, bus.clear_pulse, bus.load_pulse,
           bus.frame_err, bus.cmd_err};
    if (rst_n) begin
      if (obs != 6'b0) pulse_cnt++;
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        n_checks++;
        if (obs !== exp_q[0].exp || bus.load_digits !== exp_q[0].dig) begin
          n_fail++;
          $display("FAIL vec%0d: pulses=%b digits=%h, required pulses=%b digits=%h",
                   exp_q[0].idx, obs, bus.load_digits, exp_q[0].exp, exp_q[0].dig);
        end
        void'(exp_q.pop_front());
      end else if (obs != 6'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL stray_pulse at cycle %0d: pulses=%b, required 000000", cyc, obs);
      end
    end
  end

  task automatic wait_bit();
    repeat (Cpb) @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [7:0] data, input logic stop, input int idle_bits,
                     input logic [5:0] exp, input logic [15:0] dig);
    vec_t v;
    v.data = data; v.stop = stop; v.idle_bits = idle_bits; v.exp = exp; v.dig = dig;
    tbl.push_back(v);
  endtask

  // Called just after a posedge; drives one 8N1 frame and books its expectation.
  task automatic send_frame(input vec_t v, input int idx);
    exp_t e;
    e.cyc = cyc + Lat;
    e.exp = v.exp;
    e.dig = v.dig;
    e.idx = idx;
    exp_q.push_back(e);
    bus.usb_rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      bus.usb_rx = v.data[i];
      wait_bit();
    end
    bus.usb_rx = v.stop;
    wait_bit();
    if (v.idle_bits > 0) begin
      bus.usb_rx = 1'b1;
      repeat (v.idle_bits) wait_bit();
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic send_one(input logic [7:0] data, input logic [5:0] exp,
                          input logic [15:0] dig, input int idx);
    vec_t v;
    v.data = data; v.stop = 1'b1; v.idle_bits = 2; v.exp = exp; v.dig = dig;
    send_frame(v, idx);
  endtask

  initial begin
    int n0;
    cyc       = 0;
    n_checks  = 0;
    n_fail    = 0;
    pulse_cnt = 0;
    rst_n     = 1'b0;
    bus.usb_rx = 1'b1;

    // Table: bytes are sent back-to-back unless idle_bits says otherwise.
    add(8'h47, 1'b1, 1, ExStart, 16'h0000);  // 'G'
    add(8'h54, 1'b1, 0, ExNone,  16'h0000);  // "T4259\r"
    add(8'h34, 1'b1, 0, ExNone,  16'h0000);
    add(8'h32, 1'b1, 0, ExNone,  16'h0000);
    add(8'h35, 1'b1, 0, ExNone,  16'h0000);
    add(8'h39, 1'b1, 0, ExNone,  16'h0000);
    add(8'h0D, 1'b1, 0, ExLoad,  16'h4259);
    add(8'h0A, 1'b1, 1, ExNone,  16'h4259);  // LF ignored
    add(8'h54, 1'b1, 0, ExNone,  16'h4259);  // "T7000\r": '7' out of range
    add(8'h37, 1'b1, 0, ExCmd,   16'h4259);
    add(8'h30, 1'b1, 0, ExNone,  16'h4259);
    add(8'h30, 1'b1, 0, ExNone,  16'h4259);
    add(8'h30, 1'b1, 0, ExNone,  16'h4259);
    add(8'h0D, 1'b1, 0, ExNone,  16'h4259);
    add(8'h52, 1'b1, 1, ExClear, 16'h4259);  // 'R'
    add(8'h54, 1'b1, 0, ExNone,  16'h4259);  // "T12" then broken frame
    add(8'h31, 1'b1, 0, ExNone,  16'h4259);
    add(8'h32, 1'b1, 0, ExNone,  16'h4259);
    add(8'h33, 1'b0, 2, ExFrCmd, 16'h4259);
    add(8'h54, 1'b1, 0, ExNone,  16'h4259);  // "T0105\r"
    add(8'h30, 1'b1, 0, ExNone,  16'h4259);
    add(8'h31, 1'b1, 0, ExNone,  16'h4259);
    add(8'h30, 1'b1, 0, ExNone,  16'h4259);
    add(8'h35, 1'b1, 0, ExNone,  16'h4259);
    add(8'h0D, 1'b1, 1, ExLoad,  16'h0105);
    add(8'h54, 1'b1, 0, ExNone,  16'h0105);  // second 'T' aborts
    add(8'h54, 1'b1, 1, ExCmd,   16'h0105);
    add(8'h54, 1'b1, 0, ExNone,  16'h0105);  // "T5959\r": range upper bounds
    add(8'h35, 1'b1, 0, ExNone,  16'h0105);
    add(8'h39, 1'b1, 0, ExNone,  16'h0105);
    add(8'h35, 1'b1, 0, ExNone,  16'h0105);
    add(8'h39, 1'b1, 0, ExNone,  16'h0105);
    add(8'h0D, 1'b1, 1, ExLoad,  16'h5959);
    add(8'h54, 1'b1, 0, ExNone,  16'h5959);  // "T006": seconds tens too big
    add(8'h30, 1'b1, 0, ExNone,  16'h5959);
    add(8'h30, 1'b1, 0, ExNone,  16'h5959);
    add(8'h36, 1'b1, 0, ExCmd,   16'h5959);
    add(8'h54, 1'b1, 0, ExNone,  16'h5959);  // "T1234X": bad terminator
    add(8'h31, 1'b1, 0, ExNone,  16'h5959);
    add(8'h32, 1'b1, 0, ExNone,  16'h5959);
    add(8'h33, 1'b1, 0, ExNone,  16'h5959);
    add(8'h34, 1'b1, 0, ExNone,  16'h5959);
    add(8'h58, 1'b1, 3, ExCmd,   16'h5959);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_pulses", {26'd0, bus.start_pulse, bus.stop_pulse, bus.clear_pulse,
                           bus.load_pulse, bus.frame_err, bus.cmd_err}, 32'd0);
    check("reset_digits", {16'd0, bus.load_digits}, 32'd0);
    rst_n = 1'b1;
    repeat (3) wait_bit();

    for (int i = 0; i < tbl.size(); i++) send_frame(tbl[i], i);

    // Start-bit glitch shorter than half a bit: must be dropped silently.
    n0 = pulse_cnt;
    bus.usb_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.usb_rx = 1'b1;
    repeat (3) wait_bit();
    check("glitch_no_pulse", pulse_cnt, n0);
    send_one(8'h50, ExStop, 16'h5959, 100);  // 'P'

    // Reset in data bit 3 with the line held low across the release.
    bus.usb_rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 3; i++) begin
      bus.usb_rx = 1'b1;
      wait_bit();
    end
    bus.usb_rx = 1'b0;
    repeat (Half) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_pulses", {26'd0, bus.start_pulse, bus.stop_pulse, bus.clear_pulse,
                              bus.load_pulse, bus.frame_err, bus.cmd_err}, 32'd0);
    check("midreset_digits", {16'd0, bus.load_digits}, 32'd0);
    repeat (Cpb) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = pulse_cnt;
    repeat (Half) @(posedge clk);
    #1;
    bus.usb_rx = 1'b1;
    repeat (6) wait_bit();
    check("post_reset_no_pulse", pulse_cnt, n0);
    check("post_reset_digits", {16'd0, bus.load_digits}, 32'd0);
    send_one(8'h47, ExStart, 16'h0000, 101);  // 'G'

    // Let the last expectations drain; anything still queued was never seen.
    repeat (2 * Lat) @(posedge clk);
    #1;
    check("all_expectations_seen", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
